// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the SPI-driven PWM configuration block.
package pwm_cfg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the synchronised value.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/pwm_spi_config_ctrl.sv
// SPI mode-0 write-only target that loads the PWM peripheral's five
// configuration registers from 16-bit {rw, addr[6:0], data[7:0]} frames.
module pwm_spi_config_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = pwm_cfg_pkg::FRAME_BITS,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_commit,
  output logic       frame_err
);

  import pwm_cfg_pkg::*;

  localparam int              CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF   = CNT_W'(FRAME_BITS + 1);
  localparam logic [6:0]      ADDR_LIMIT = 7'(NUM_REGS);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(sclk),
    .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .async_in(copi),
    .sync_out(copi_s), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_in(ncs),
    .sync_out(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  // Mode 0 only needs sclk rises and the synchronised copi level.
  logic unused_edges;
  assign unused_edges = ^{sclk_s, sclk_fall, copi_rise, copi_fall};

  state_e                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;

  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  assign frame_rw   = shift_reg[FRAME_BITS-1];
  assign frame_addr = shift_reg[FRAME_BITS-2 -: 7];
  assign frame_data = shift_reg[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      wr_commit       <= 1'b0;
      frame_err       <= 1'b0;
      // NOTE: these are five discrete flops, not a RAM, so clearing them in
      // reset is cheap and gives the PWM block a known-off configuration.
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_commit <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end

        SHIFT: begin
          // A deselect wins over a coincident sclk edge, so that bit is dropped.
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
            if (bit_cnt != CNT_OVF) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        COMMIT: begin
          if (bit_cnt != CNT_FULL) begin
            frame_err <= 1'b1;
          end else if (frame_rw) begin
            if (frame_addr < ADDR_LIMIT) begin
              wr_commit <= 1'b1;
              case (frame_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end

          // A very short deselect can land its fall here; start the next frame.
          if (ncs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_spi_config_ctrl.sv
// Directed bench: bit-bangs SPI frames at clk/10 and checks register
// contents, strobe counts and commit latency.
module tb_pwm_spi_config_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_commit;
  logic       frame_err;

  pwm_spi_config_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .FRAME_BITS (16),
    .NUM_REGS   (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_commit      (wr_commit),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  logic [39:0] regs_now;
  assign regs_now = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                     en_reg_out_15_8, en_reg_out_7_0};

  int checks   = 0;
  int errors   = 0;
  int n_commit = 0;
  int n_err    = 0;

  always @(negedge clk) begin
    if (wr_commit) n_commit++;
    if (frame_err) n_err++;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = d[i];
      clk_n(HALF);
      sclk = 1'b1;
      clk_n(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int n);
    ncs = 1'b0;
    clk_n(HALF);
    shift_bits(d, n);
    clk_n(HALF);
    ncs = 1'b1;
  endtask

  // Bounded watch after deselect: cycle of first strobe (0 = none) and the
  // register snapshot in that cycle.
  task automatic watch(output int lat, output logic [39:0] snap);
    lat  = 0;
    snap = regs_now;
    for (int k = 1; k <= 12; k++) begin
      clk_n(1);
      if (lat == 0 && (wr_commit || frame_err)) begin
        lat  = k;
        snap = regs_now;
      end
    end
  endtask

  int          lat;
  logic [39:0] snap;
  int          c0;
  int          e0;

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    clk_n(3);
    rst = 1'b0;
    clk_n(5);

    check("reset_regs", regs_now, 40'h0);
    check("reset_strobes", {38'h0, wr_commit, frame_err}, 40'h0);

    // Single write to addr 0x00
    c0 = n_commit; e0 = n_err;
    send_frame(32'h80FF, 16);
    watch(lat, snap);
    check("latency_ok", 40'(lat >= 1 && lat <= SYNC_STAGES + 3), 40'h1);
    check("value_at_commit", snap, 40'h00_00_00_00_FF);
    check("regs_after_80ff", regs_now, 40'h00_00_00_00_FF);
    check("commit_cnt_80ff", 40'(n_commit - c0), 40'd1);
    check("err_cnt_80ff", 40'(n_err - e0), 40'd0);

    // Duty then PWM enable low
    c0 = n_commit; e0 = n_err;
    send_frame(32'h8480, 16);
    watch(lat, snap);
    check("duty_at_commit", snap, 40'h80_00_00_00_FF);
    send_frame(32'h8201, 16);
    watch(lat, snap);
    check("regs_after_two", regs_now, 40'h80_00_01_00_FF);
    check("commit_cnt_two", 40'(n_commit - c0), 40'd2);
    check("err_cnt_two", 40'(n_err - e0), 40'd0);

    // Read frame is silent; write to addr 0x05 is rejected
    c0 = n_commit; e0 = n_err;
    send_frame(32'h00AA, 16);
    watch(lat, snap);
    check("read_no_strobe", 40'(lat), 40'd0);
    send_frame(32'h85AA, 16);
    watch(lat, snap);
    check("bad_addr_err_cnt", 40'(n_err - e0), 40'd1);
    check("bad_addr_commit_cnt", 40'(n_commit - c0), 40'd0);
    check("bad_addr_regs", regs_now, 40'h80_00_01_00_FF);

    // Short (15) and long (17) frames, then a correct one
    c0 = n_commit; e0 = n_err;
    send_frame(32'h40AA, 15);
    watch(lat, snap);
    send_frame(32'h102AB, 17);
    watch(lat, snap);
    check("len_err_cnt", 40'(n_err - e0), 40'd2);
    check("len_err_regs", regs_now, 40'h80_00_01_00_FF);
    send_frame(32'h8155, 16);
    watch(lat, snap);
    check("len_ok_regs", regs_now, 40'h80_00_01_55_FF);
    check("len_commit_cnt", 40'(n_commit - c0), 40'd1);

    // Reset after 8 bits of a frame
    c0 = n_commit; e0 = n_err;
    ncs = 1'b0;
    clk_n(HALF);
    shift_bits(32'h80, 8);
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    clk_n(HALF);
    ncs = 1'b1;
    watch(lat, snap);
    check("midrst_no_strobe", 40'((n_commit - c0) + (n_err - e0)), 40'd0);
    check("midrst_regs", regs_now, 40'h0);
    send_frame(32'h8033, 16);
    watch(lat, snap);
    check("post_rst_regs", regs_now, 40'h00_00_00_00_33);

    // sclk activity with ncs high must be ignored
    c0 = n_commit; e0 = n_err;
    for (int i = 0; i < 20; i++) begin
      copi = i[0];
      sclk = ~sclk;
      clk_n(HALF);
    end
    watch(lat, snap);
    check("idle_sclk_no_strobe", 40'((n_commit - c0) + (n_err - e0)), 40'd0);
    check("idle_sclk_regs", regs_now, 40'h00_00_00_00_33);

    // Back-to-back frames: second select lands the cycle after COMMIT
    c0 = n_commit; e0 = n_err;
    send_frame(32'h8312, 16);
    clk_n(2);
    send_frame(32'h8434, 16);
    watch(lat, snap);
    check("b2b_commit_cnt", 40'(n_commit - c0), 40'd2);
    check("b2b_err_cnt", 40'(n_err - e0), 40'd0);
    check("b2b_regs", regs_now, 40'h34_12_00_00_33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
